// File: rtl/res_block_sched.sv
// Residual-block scheduler: sequences conv1 -> ReLU -> mid, then conv2 -> skip-add -> ReLU -> out
// on one shared conv datapath. Define RES_SCHED_PERF_EN to enable the last_cycles frame counter.
module res_block_sched #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = $clog2(TIMEOUT_CYCLES),
    parameter int FRAME_CNT_W    = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   conv_valid,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic                   conv_launch,
    output logic                   src_sel,
    output logic                   wt_sel,
    output logic                   mid_we,
    output logic                   out_we,
    output logic                   add_en,
    output logic [FRAME_CNT_W-1:0] frame_count,
    output logic [15:0]            last_cycles
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LAUNCH1,
        S_WAIT1,
        S_CAP1,
        S_LAUNCH2,
        S_WAIT2,
        S_CAP2,
        S_DONE,
        S_ERR
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] wd;
    logic             wd_expired;
    logic             in_wait;
    logic             entering_wait;
    logic             pass2_q;

    assign in_wait       = (state == S_WAIT1) || (state == S_WAIT2);
    assign wd_expired    = (wd == CNT_W'(TIMEOUT_CYCLES - 1));
    assign entering_wait = ((state_nx == S_WAIT1) || (state_nx == S_WAIT2)) && (state_nx != state);

    // abort outranks everything outside IDLE; in WAIT, valid outranks timeout
    always_comb begin
        state_nx = state;
        if ((state != S_IDLE) && abort) begin
            state_nx = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE:    if (start) state_nx = S_LAUNCH1;
                S_LAUNCH1: state_nx = S_WAIT1;
                S_WAIT1: begin
                    if (conv_valid)      state_nx = S_CAP1;
                    else if (wd_expired) state_nx = S_ERR;
                end
                S_CAP1:    state_nx = S_LAUNCH2;
                S_LAUNCH2: state_nx = S_WAIT2;
                S_WAIT2: begin
                    if (conv_valid)      state_nx = S_CAP2;
                    else if (wd_expired) state_nx = S_ERR;
                end
                S_CAP2:    state_nx = S_DONE;
                S_DONE:    state_nx = S_IDLE;
                S_ERR:     state_nx = S_IDLE;
                default:   state_nx = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            wd          <= '0;
            err         <= 1'b0;
            frame_count <= '0;
            pass2_q     <= 1'b0;
        end else begin
            state <= state_nx;

            if (entering_wait)
                wd <= '0;
            else if (in_wait && !conv_valid)
                wd <= wd + 1'b1;

            if ((state == S_IDLE) && start)
                err <= 1'b0;
            else if ((state == S_ERR) && !abort)
                err <= 1'b1;

            if ((state == S_DONE) && !abort)
                frame_count <= frame_count + 1'b1;

            // operand selects are latched as the pass-2 states are entered, so they hold steady
            pass2_q <= (state_nx == S_LAUNCH2) || (state_nx == S_WAIT2) || (state_nx == S_CAP2);
        end
    end

    assign busy        = (state != S_IDLE);
    assign done        = (state == S_DONE);
    assign conv_launch = (state == S_LAUNCH1) || (state == S_LAUNCH2);
    assign mid_we      = (state == S_CAP1);
    assign out_we      = (state == S_CAP2);
    assign add_en      = (state == S_CAP2);
    assign src_sel     = pass2_q;
    assign wt_sel      = pass2_q;

`ifdef RES_SCHED_PERF_EN
    logic [15:0] perf_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_cnt    <= '0;
            last_cycles <= '0;
        end else begin
            if ((state == S_IDLE) && (state_nx == S_LAUNCH1))
                perf_cnt <= '0;
            else if ((state != S_IDLE) && (perf_cnt != '1))
                perf_cnt <= perf_cnt + 1'b1;

            if ((state == S_DONE) && !abort)
                last_cycles <= perf_cnt;
        end
    end
`else
    assign last_cycles = '0;
`endif

endmodule

// File: tb/tb_res_block_sched.sv
// Bench for res_block_sched: hand-derived vector table, async-reset and wrap sequences,
// and random frames checked against a per-frame phase timeline model.
module tb_res_block_sched;

    localparam int T  = 4;
    localparam int FW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic          conv_valid;
    logic          busy, done, err, conv_launch, src_sel, wt_sel, mid_we, out_we, add_en;
    logic [FW-1:0] frame_count;
    logic [15:0]   last_cycles;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    res_block_sched #(
        .TIMEOUT_CYCLES(T),
        .FRAME_CNT_W   (FW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .conv_valid (conv_valid),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .conv_launch(conv_launch),
        .src_sel    (src_sel),
        .wt_sel     (wt_sel),
        .mid_we     (mid_we),
        .out_we     (out_we),
        .add_en     (add_en),
        .frame_count(frame_count),
        .last_cycles(last_cycles)
    );

    // Phase labels of a frame's timeline, one entry per clock cycle
    typedef enum int {P_IDLE, P_L1, P_W1, P_C1, P_L2, P_W2, P_C2, P_DN, P_ER} phase_t;
    phase_t tl[$];

    logic          m_err;
    logic [FW-1:0] m_fc;
    logic [15:0]   m_last;

    typedef struct {
        int l1;
        int l2;
        int abort_at;
        int exp_done;
        bit exp_err;
        int exp_fc;
        int exp_last;
    } vec_t;

    function automatic logic [7:0] ctl_of(input phase_t p);
        logic [7:0] v;  // {busy, launch, src, wt, mid_we, out_we, add_en, done}
        v    = '0;
        v[7] = (p != P_IDLE);
        v[6] = (p == P_L1) || (p == P_L2);
        v[5] = (p == P_L2) || (p == P_W2) || (p == P_C2);
        v[4] = v[5];
        v[3] = (p == P_C1);
        v[2] = (p == P_C2);
        v[1] = (p == P_C2);
        v[0] = (p == P_DN);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input phase_t p, input string tag);
        chk($sformatf("%s ctl", tag),
            {busy, conv_launch, src_sel, wt_sel, mid_we, out_we, add_en, done}, ctl_of(p));
        chk($sformatf("%s err", tag), err, m_err);
        chk($sformatf("%s frame_count", tag), frame_count, m_fc);
        chk($sformatf("%s last_cycles", tag), last_cycles, m_last);
    endtask

    // l > T means conv_valid never arrives in that pass
    task automatic build(input int l1, input int l2);
        tl.delete();
        tl.push_back(P_L1);
        for (int i = 0; i < ((l1 > T) ? T : l1); i++) tl.push_back(P_W1);
        if (l1 > T) begin
            tl.push_back(P_ER);
            return;
        end
        tl.push_back(P_C1);
        tl.push_back(P_L2);
        for (int i = 0; i < ((l2 > T) ? T : l2); i++) tl.push_back(P_W2);
        if (l2 > T) begin
            tl.push_back(P_ER);
            return;
        end
        tl.push_back(P_C2);
        tl.push_back(P_DN);
    endtask

    function automatic int frame_len(input int l1, input int l2);
        if (l1 > T) return 2 + T;
        if (l2 > T) return 4 + l1 + T;
        return 5 + l1 + l2;
    endfunction

    // Entered and left at the falling edge of an IDLE cycle
    task automatic run_frame(input int l1, input int l2, input int abort_at, input bit hold,
                             output int done_at);
        phase_t p;
        int     n;
        build(l1, l2);
        n       = tl.size();
        done_at = 0;
        check_all(P_IDLE, "idle");
        start      = 1'b1;
        abort      = 1'($urandom_range(0, 1));
        conv_valid = 1'($urandom_range(0, 1));
        @(negedge clk);
        m_err = 1'b0;
        for (int c = 1; c <= n; c++) begin
            p = tl[c-1];
            check_all(p, $sformatf("frame(%0d,%0d) cyc%0d", l1, l2, c));
            if ((done === 1'b1) && (done_at == 0)) done_at = c;
            start = hold ? 1'b1 : 1'($urandom_range(0, 1));
            abort = (c == abort_at);
            if ((p == P_W1) || (p == P_W2))
                conv_valid = (c < n) && ((tl[c] == P_C1) || (tl[c] == P_C2));
            else
                conv_valid = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (c == abort_at) break;
        end
        if (abort_at == 0) begin
            if (tl[n-1] == P_ER) begin
                m_err = 1'b1;
            end else begin
                m_fc = m_fc + 1'b1;
`ifdef RES_SCHED_PERF_EN
                m_last = 16'(4 + l1 + l2);
`endif
            end
        end
        start      = 1'b0;
        abort      = 1'b0;
        conv_valid = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        chk($sformatf("%s ctl", tag),
            {busy, conv_launch, src_sel, wt_sel, mid_we, out_we, add_en, done}, 8'h00);
        chk($sformatf("%s err", tag), err, 0);
        chk($sformatf("%s frame_count", tag), frame_count, 0);
        chk($sformatf("%s last_cycles", tag), last_cycles, 0);
    endtask

    initial begin
        vec_t vecs[7];
        int   d;
        int   l1, l2, ab, n;

        vecs[0] = '{l1: 1, l2: 1, abort_at: 0, exp_done: 7,  exp_err: 0, exp_fc: 1, exp_last: 6};
        vecs[1] = '{l1: 3, l2: 3, abort_at: 0, exp_done: 11, exp_err: 0, exp_fc: 2, exp_last: 10};
        vecs[2] = '{l1: 5, l2: 1, abort_at: 0, exp_done: 0,  exp_err: 1, exp_fc: 2, exp_last: 10};
        vecs[3] = '{l1: 2, l2: 4, abort_at: 0, exp_done: 11, exp_err: 0, exp_fc: 3, exp_last: 10};
        vecs[4] = '{l1: 1, l2: 2, abort_at: 6, exp_done: 0,  exp_err: 0, exp_fc: 3, exp_last: 10};
        vecs[5] = '{l1: 1, l2: 5, abort_at: 0, exp_done: 0,  exp_err: 1, exp_fc: 3, exp_last: 10};
        vecs[6] = '{l1: 2, l2: 1, abort_at: 0, exp_done: 8,  exp_err: 0, exp_fc: 0, exp_last: 7};

        rst        = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        conv_valid = 1'b0;
        m_err      = 1'b0;
        m_fc       = '0;
        m_last     = '0;
        @(negedge clk);
        check_zero("reset");
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 7; i++) begin
            run_frame(vecs[i].l1, vecs[i].l2, vecs[i].abort_at, 1'b0, d);
            chk($sformatf("vec%0d done_cycle", i), d, vecs[i].exp_done);
            chk($sformatf("vec%0d err", i), err, vecs[i].exp_err);
            chk($sformatf("vec%0d frame_count", i), frame_count, vecs[i].exp_fc);
`ifdef RES_SCHED_PERF_EN
            chk($sformatf("vec%0d last_cycles", i), last_cycles, vecs[i].exp_last);
`else
            chk($sformatf("vec%0d last_cycles", i), last_cycles, 0);
`endif
        end

        // asynchronous reset while waiting in pass 1
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        m_err = 1'b0;
        check_all(P_L1, "pre-reset launch");
        @(negedge clk);
        check_all(P_W1, "pre-reset wait");
        #2 rst = 1'b0;
        #1 check_zero("async reset");
        @(negedge clk);
        check_zero("held reset");
        rst    = 1'b1;
        m_err  = 1'b0;
        m_fc   = '0;
        m_last = '0;

        // four back-to-back frames with start held: counter wraps
        for (int i = 0; i < 4; i++) begin
            run_frame($urandom_range(1, T), $urandom_range(1, T), 0, 1'b1, d);
            chk($sformatf("wrap%0d frame_count", i), frame_count, (i + 1) % 4);
        end

        for (int i = 0; i < 40; i++) begin
            l1 = $urandom_range(1, T + 1);
            l2 = $urandom_range(1, T + 1);
            n  = frame_len(l1, l2);
            ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, n - 1) : 0;
            run_frame(l1, l2, ab, 1'($urandom_range(0, 1)), d);
        end
        check_all(P_IDLE, "final idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/res_block_sched.md
Name: res_block_sched

Overview:
Control FSM that time-shares one conv3x3 datapath instance between the two convolutions of a residual block.
- Pass 1 runs conv1: input tensor with weight set 1, result captured after ReLU into the intermediate register.
- Pass 2 runs conv2: intermediate register with weight set 2, then skip-add and ReLU into the output register.
- Sits between the top-level start/done handshake and the conv/relu/add datapath. Drives only mux selects, launch pulses and register write enables; carries no tensor data.

Parameters:
- TIMEOUT_CYCLES, 64: max WAIT-state cycles allowed per pass before the timeout error fires (must be >= 2).
- CNT_W, $clog2(TIMEOUT_CYCLES): watchdog counter width (derived; do not override).
- FRAME_CNT_W, 16: width of the completed-frame counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  request to process one frame; sampled only in IDLE.
- abort  in  1  cancel the current frame; sampled in any non-IDLE state.
- conv_valid  in  1  datapath result valid; honoured only in WAIT1/WAIT2.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse, frame completed.
- err  out  1  sticky timeout flag.
- conv_launch  out  1  one-cycle pulse that starts the conv datapath.
- src_sel  out  1  0 = input tensor, 1 = intermediate register.
- wt_sel  out  1  0 = weight/bias set 1, 1 = set 2.
- mid_we  out  1  write enable for the intermediate register.
- out_we  out  1  write enable for the output register.
- add_en  out  1  enables the skip-add path ahead of the final ReLU.
- frame_count  out  FRAME_CNT_W  count of completed frames.
- last_cycles  out  16  perf counter (see Optional Feature).

Behaviour:
- States: IDLE, LAUNCH1, WAIT1, CAP1, LAUNCH2, WAIT2, CAP2, DONE, ERR. Encoding is free.
- All control outputs are Moore, decoded from the registered state. src_sel and wt_sel are registered at LAUNCH entry and hold through CAP of that pass.
- Reset (rst low, asynchronous) forces:
  - state = IDLE;
  - all outputs 0, including err, frame_count and last_cycles;
  - watchdog = 0.
- Transitions:
  - IDLE: start=1 -> LAUNCH1; clears err.
  - LAUNCH1: conv_launch=1, src_sel=0, wt_sel=0 -> WAIT1.
  - WAIT1: conv_valid=1 -> CAP1.
  - CAP1: mid_we=1 -> LAUNCH2.
  - LAUNCH2: conv_launch=1, src_sel=1, wt_sel=1 -> WAIT2.
  - WAIT2: conv_valid=1 -> CAP2.
  - CAP2: out_we=1, add_en=1 -> DONE.
  - DONE: done=1, frame_count+1 (wraps to 0) -> IDLE.
  - ERR: err set to 1 -> IDLE. No done pulse, frame_count unchanged.
- Watchdog:
  - Cleared on entry to WAIT1/WAIT2; increments each WAIT cycle without conv_valid.
  - If watchdog == TIMEOUT_CYCLES-1 and conv_valid=0 -> ERR.
- Priority in a WAIT state: abort > conv_valid > timeout.
- abort in any non-IDLE state, including DONE/ERR -> IDLE on the next edge:
  - no done, err unchanged, frame_count unchanged;
  - outputs drop to 0 at that edge.
- start while busy is ignored and not queued. start and abort together in IDLE: start wins (abort is ignored in IDLE).
- conv_valid outside WAIT1/WAIT2 is ignored.
- Latency, with conv_valid arriving L>=1 cycles after the LAUNCH cycle:
  - done asserts 5+2L cycles after the edge that samples start;
  - busy rises 1 cycle after that edge.
- Back-to-back frames: start held high makes IDLE last exactly 1 cycle between frames.

Optional Feature:
- Macro: RES_SCHED_PERF_EN.
- Defined:
  - a 16-bit cycle counter clears on LAUNCH1 entry and increments each cycle through DONE, saturating at 0xFFFF;
  - it is latched into last_cycles in DONE;
  - abort/ERR frames do not update last_cycles.
- Undefined: last_cycles is tied to 0 and the counter logic is absent.

Test Plan:
- Nominal, L=1: reset, start pulse at edge 0, conv_valid one cycle after each conv_launch -> done at cycle 7; mid_we at cycle 3; out_we+add_en at cycle 6; frame_count=1; err=0.
- Latency sweep: L=3 -> done at cycle 11; with PERF_EN, last_cycles=10. L=1 -> last_cycles=6.
- Timeout, TIMEOUT_CYCLES=4: conv_valid never asserted -> ERR after 4 WAIT1 cycles; err=1, no done, busy low next cycle; a new start clears err.
- Valid on last timeout cycle: conv_valid asserted on the 4th WAIT2 cycle -> proceeds to CAP2, err stays 0.
- Abort mid-pass: abort asserted in WAIT2 together with conv_valid -> IDLE next edge; no out_we, no done; frame_count unchanged.
- Reset mid-operation and wrap: rst low asynchronously in WAIT1 -> all outputs 0 immediately. With FRAME_CNT_W=2, 4 frames -> frame_count returns to 0; start held high -> 1 IDLE cycle between frames.
